wg_barrier_ctrl: RTL and testbench

//  Workgroup barrier tracker in the fetch/issue path, directly downstream of the workgroup-info table.
//  On each s_barrier arrival it reads the wavefront's workgroup id and wavefront count from that table.
//  It holds the arriving wavefront and counts arrivals per workgroup.

---
 rtl/wg_barrier_ctrl.sv | 111 +++++++++++
 tb/tb_wg_barrier_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/wg_barrier_ctrl.sv
// Workgroup barrier tracker: holds wavefronts that reach s_barrier and releases all members
// of a workgroup together once its last member arrives.
module wg_barrier_ctrl #(
    parameter int NUM_WF = 40,
    parameter int WFID_W = 6,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              barrier_req,
    input  logic [WFID_W-1:0] barrier_wfid,
    output logic [WFID_W-1:0] lookup_wfid,
    input  logic [WFID_W-1:0] lookup_wgid,
    input  logic [CNT_W-1:0]  lookup_wf_count,
    input  logic              halt,
    input  logic [WFID_W-1:0] halt_wfid,
    output logic [NUM_WF-1:0] waiting_mask,
    output logic              release_valid,
    output logic [NUM_WF-1:0] release_mask,
    output logic              err_dup
);

    logic [NUM_WF-1:0] wait_q, wait_d;
    logic [WFID_W-1:0] wg_of_q [NUM_WF];
    logic [WFID_W-1:0] wg_of_d [NUM_WF];
    logic [CNT_W-1:0]  arr_cnt_q [NUM_WF];
    logic [CNT_W-1:0]  arr_cnt_d [NUM_WF];

    logic              release_valid_q, release_valid_d;
    logic [NUM_WF-1:0] release_mask_q, release_mask_d;
    logic              err_dup_q, err_dup_d;

    logic              w_ok, g_ok, h_ok;
    logic              halt_hit, arr_valid;
    logic [WFID_W-1:0] halt_g;
    logic [CNT_W-1:0]  c_eff, n_cnt;

    assign lookup_wfid = barrier_wfid;

    assign w_ok     = 32'(barrier_wfid) < NUM_WF;
    assign g_ok     = 32'(lookup_wgid) < NUM_WF;
    assign h_ok     = 32'(halt_wfid) < NUM_WF;
    assign halt_hit = halt && h_ok && wait_q[halt_wfid];
    assign halt_g   = wg_of_q[halt_wfid];
    // A halt on the arriving slot kills the arrival outright (and suppresses err_dup).
    assign arr_valid = barrier_req && w_ok && g_ok && !(halt && (halt_wfid == barrier_wfid));
    assign c_eff     = (lookup_wf_count == '0) ? CNT_W'(1) : lookup_wf_count;

    always_comb begin
        wait_d          = wait_q;
        wg_of_d         = wg_of_q;
        arr_cnt_d       = arr_cnt_q;
        release_valid_d = 1'b0;
        release_mask_d  = '0;
        err_dup_d       = 1'b0;
        n_cnt           = '0;

        // Halt is applied first so a same-cycle arrival sees the decremented count.
        if (halt_hit) begin
            wait_d[halt_wfid] = 1'b0;
            if (arr_cnt_d[halt_g] != '0) begin
                arr_cnt_d[halt_g] = arr_cnt_d[halt_g] - CNT_W'(1);
            end
        end

        if (arr_valid) begin
            n_cnt = arr_cnt_d[lookup_wgid] + CNT_W'(1);
            if (wait_q[barrier_wfid]) begin
                err_dup_d = 1'b1;
            end else if (n_cnt >= c_eff) begin
                arr_cnt_d[lookup_wgid] = '0;
                for (int i = 0; i < NUM_WF; i++) begin
                    if (wait_d[i] && (wg_of_q[i] == lookup_wgid)) begin
                        release_mask_d[i] = 1'b1;
                    end
                end
                release_mask_d[barrier_wfid] = 1'b1;
                release_valid_d              = 1'b1;
                wait_d                       = wait_d & ~release_mask_d;
            end else begin
                wait_d[barrier_wfid]   = 1'b1;
                wg_of_d[barrier_wfid]  = lookup_wgid;
                arr_cnt_d[lookup_wgid] = n_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q          <= '0;
            wg_of_q         <= '{default: '0};
            arr_cnt_q       <= '{default: '0};
            release_valid_q <= 1'b0;
            release_mask_q  <= '0;
            err_dup_q       <= 1'b0;
        end else begin
            wait_q          <= wait_d;
            wg_of_q         <= wg_of_d;
            arr_cnt_q       <= arr_cnt_d;
            release_valid_q <= release_valid_d;
            release_mask_q  <= release_mask_d;
            err_dup_q       <= err_dup_d;
        end
    end

    assign waiting_mask  = wait_q;
    assign release_valid = release_valid_q;
    assign release_mask  = release_mask_q;
    assign err_dup       = err_dup_q;

endmodule

// File: tb/tb_wg_barrier_ctrl.sv
// Bench for wg_barrier_ctrl: directed scenarios plus random traffic checked against a model
// that tracks only the set of waiting wavefronts and their groups.
module tb_wg_barrier_ctrl;

    localparam int NUM_WF = 40;
    localparam int WFID_W = 6;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              barrier_req;
    logic [WFID_W-1:0] barrier_wfid;
    logic [WFID_W-1:0] lookup_wfid;
    logic [WFID_W-1:0] lookup_wgid;
    logic [CNT_W-1:0]  lookup_wf_count;
    logic              halt;
    logic [WFID_W-1:0] halt_wfid;
    logic [NUM_WF-1:0] waiting_mask;
    logic              release_valid;
    logic [NUM_WF-1:0] release_mask;
    logic              err_dup;

    int checks = 0;
    int errors = 0;

    // Model: who is waiting and in which group; arrival count of a group = its waiter count.
    bit m_wait [NUM_WF];
    int m_wg   [NUM_WF];
    logic              exp_rv;
    logic [NUM_WF-1:0] exp_rm;
    logic              exp_dup;

    wg_barrier_ctrl #(.NUM_WF(NUM_WF), .WFID_W(WFID_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .barrier_req    (barrier_req),
        .barrier_wfid   (barrier_wfid),
        .lookup_wfid    (lookup_wfid),
        .lookup_wgid    (lookup_wgid),
        .lookup_wf_count(lookup_wf_count),
        .halt           (halt),
        .halt_wfid      (halt_wfid),
        .waiting_mask   (waiting_mask),
        .release_valid  (release_valid),
        .release_mask   (release_mask),
        .err_dup        (err_dup)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [NUM_WF-1:0] model_mask();
        logic [NUM_WF-1:0] m = '0;
        for (int i = 0; i < NUM_WF; i++) m[i] = m_wait[i];
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_WF; i++) begin
            m_wait[i] = 1'b0;
            m_wg[i]   = 0;
        end
    endtask

    // One clock: drive inputs, predict, then check registered outputs just after the edge.
    task automatic cyc(input bit req, input int w, input int g, input int c,
                       input bit h, input int hw);
        bit arr;
        int members;
        barrier_req     = req;
        barrier_wfid    = WFID_W'(w);
        lookup_wgid     = WFID_W'(g);
        lookup_wf_count = CNT_W'(c);
        halt            = h;
        halt_wfid       = WFID_W'(hw);
        #1;
        if (req) chk("lookup_wfid", 64'(lookup_wfid), 64'(w));

        exp_rv  = 1'b0;
        exp_rm  = '0;
        exp_dup = 1'b0;
        arr     = req && !(h && hw == w);
        if (h && m_wait[hw]) m_wait[hw] = 1'b0;
        if (arr && m_wait[w]) begin
            exp_dup = 1'b1;
        end else if (arr) begin
            members = 0;
            for (int i = 0; i < NUM_WF; i++) if (m_wait[i] && m_wg[i] == g) members++;
            if (members + 1 >= ((c == 0) ? 1 : c)) begin
                exp_rv = 1'b1;
                for (int i = 0; i < NUM_WF; i++) begin
                    if (m_wait[i] && m_wg[i] == g) begin
                        exp_rm[i] = 1'b1;
                        m_wait[i] = 1'b0;
                    end
                end
                exp_rm[w] = 1'b1;
            end else begin
                m_wait[w] = 1'b1;
                m_wg[w]   = g;
            end
        end

        @(posedge clk);
        #1;
        chk("release_valid", 64'(release_valid), 64'(exp_rv));
        chk("release_mask", 64'(release_mask), 64'(exp_rm));
        chk("err_dup", 64'(err_dup), 64'(exp_dup));
        chk("waiting_mask", 64'(waiting_mask), 64'(model_mask()));
        barrier_req = 1'b0;
        halt        = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 0, 0, 0, 1'b0, 0);
    endtask

    initial begin
        int w, g, c, hw;
        bit req, h;
        rst             = 1'b0;
        barrier_req     = 1'b0;
        barrier_wfid    = '0;
        lookup_wgid     = '0;
        lookup_wf_count = '0;
        halt            = 1'b0;
        halt_wfid       = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_waiting", 64'(waiting_mask), 64'd0);
        chk("reset_rv", 64'(release_valid), 64'd0);
        chk("reset_rm", 64'(release_mask), 64'd0);
        chk("reset_dup", 64'(err_dup), 64'd0);
        rst = 1'b1;
        idle();

        // Group 8 of four, arrivals spread out.
        cyc(1, 8, 8, 4, 0, 0);
        idle();
        cyc(1, 9, 8, 4, 0, 0);
        cyc(1, 10, 8, 4, 0, 0);
        chk("g8_waiting", 64'(waiting_mask), 64'h700);
        idle();
        idle();
        cyc(1, 11, 8, 4, 0, 0);
        chk("g8_release_mask", 64'(release_mask), 64'hF00);
        chk("g8_waiting_clear", 64'(waiting_mask), 64'd0);
        idle();

        // Single-wavefront groups, count 1 and count 0.
        cyc(1, 5, 5, 1, 0, 0);
        chk("single_c1", 64'(release_mask), 64'h20);
        cyc(1, 5, 5, 0, 0, 0);
        chk("single_c0", 64'(release_mask), 64'h20);
        idle();

        // Duplicate arrival must not bump the counter.
        cyc(1, 12, 12, 3, 0, 0);
        cyc(1, 12, 12, 3, 0, 0);
        chk("dup_flag", 64'(err_dup), 64'd1);
        cyc(1, 13, 12, 3, 0, 0);
        chk("dup_no_release", 64'(release_valid), 64'd0);
        cyc(1, 14, 12, 3, 0, 0);
        chk("dup_release_mask", 64'(release_mask), 64'h7000);

        // Halted waiter re-arrives; release only once count is genuinely reached.
        cyc(1, 20, 20, 3, 0, 0);
        cyc(1, 21, 20, 3, 0, 0);
        cyc(0, 0, 0, 0, 1, 21);
        cyc(1, 21, 20, 3, 0, 0);
        chk("halt_no_early", 64'(release_valid), 64'd0);
        cyc(1, 22, 20, 3, 0, 0);
        chk("halt_release_mask", 64'(release_mask), 64'h70_0000);

        // Halt of a group member during what would have been the completing arrival.
        cyc(1, 33, 33, 3, 0, 0);
        cyc(1, 34, 33, 3, 0, 0);
        cyc(1, 35, 33, 3, 1, 34);
        chk("halt_same_cycle", 64'(release_valid), 64'd0);
        cyc(1, 36, 33, 3, 1, 35);
        cyc(1, 37, 33, 3, 1, 33);
        // Halt on the arriving slot drops the arrival.
        cyc(1, 38, 33, 1, 1, 38);
        chk("halt_wins", 64'(release_valid), 64'd0);

        // Interleaved groups 0 and 30.
        cyc(1, 0, 0, 2, 0, 0);
        cyc(1, 30, 30, 2, 0, 0);
        cyc(1, 1, 0, 2, 0, 0);
        chk("ilv_mask0", 64'(release_mask), 64'h3);
        cyc(1, 31, 30, 2, 0, 0);
        chk("ilv_mask30", 64'(release_mask), 64'hC000_0000);
        idle();

        // Reset mid-barrier drops waiters; the group counts from zero afterwards.
        cyc(1, 25, 25, 3, 0, 0);
        cyc(1, 26, 25, 3, 0, 0);
        rst = 1'b0;
        #1;
        chk("rst_async_waiting", 64'(waiting_mask), 64'd0);
        chk("rst_async_rv", 64'(release_valid), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1, 27, 25, 3, 0, 0);
        chk("rst_count_restart", 64'(waiting_mask), 64'h800_0000);
        cyc(1, 28, 25, 3, 0, 0);
        chk("rst_no_release", 64'(release_valid), 64'd0);

        // Random traffic over a few small groups so completions, dups and halts collide often.
        for (int k = 0; k < 1500; k++) begin
            req = ($urandom_range(0, 1) == 1);
            w   = $urandom_range(0, 15);
            g   = $urandom_range(0, 3);
            c   = $urandom_range(0, 5);
            h   = ($urandom_range(0, 5) == 0);
            hw  = ($urandom_range(0, 3) == 0) ? w : $urandom_range(0, 15);
            cyc(req, w, g, c, h, hw);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
